// File: rtl/bus_multi_timer.sv
// bus_multi_timer: NUM_CH-channel bus interval timer, shared prescaler, one raise/ack interrupt; COUNT readback enabled by BUS_MULTI_TIMER_COUNT_READ_EN
module bus_multi_timer #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int NUM_CH = 4,
  parameter int PRESCALE = 50000
) (
  input logic CLK,
  input logic RESET,
  inout wire [7:0] BUS_DATA,
  input logic [7:0] BUS_ADDR,
  input logic BUS_WE,
  output logic BUS_INTERRUPT_RAISE,
  input logic BUS_INTERRUPT_ACK
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
`ifdef BUS_MULTI_TIMER_COUNT_READ_EN
  localparam int WIN = 4 + 2 * NUM_CH;
`else
  localparam int WIN = 4 + NUM_CH;
`endif
  logic [PW-1:0] pre;
  logic tick, in_win, wr, rd, oe;
  logic [7:0] off, rmux, rdata;
  logic [NUM_CH-1:0] ctrl, status, mask, mode, wdata, expire, clr;
  logic [7:0] period [NUM_CH];
  logic [7:0] count [NUM_CH];
  assign off = BUS_ADDR - BASE_ADDR;
  assign in_win = off < 8'(WIN);
  assign wr = BUS_WE && in_win;
  assign rd = !BUS_WE && in_win;
  assign wdata = BUS_DATA[NUM_CH-1:0];
  assign tick = pre == PW'(PRESCALE - 1);
  assign BUS_DATA = oe ? rdata : 8'bz;
  // Terminal-count detection per channel, and pending bits to clear from W1C and ACK
  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_CH; i++)
      expire[i] = tick && ctrl[i] && period[i] != 8'd0 && count[i] == period[i] - 8'd1;
    clr = (wr && off == 8'd1 ? wdata : '0) | (BUS_INTERRUPT_ACK ? mask : '0);
  end
  // Readback mux; unmapped offsets and bits at or above NUM_CH read 0
  always_comb begin
    rmux = off == 8'd0 ? 8'(ctrl) : off == 8'd1 ? 8'(status) : off == 8'd2 ? 8'(mask) : off == 8'd3 ? 8'(mode) : 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (off == 8'(4 + i)) rmux = period[i];
`ifdef BUS_MULTI_TIMER_COUNT_READ_EN
      if (off == 8'(4 + NUM_CH + i)) rmux = count[i];
`endif
    end
  end
  // Prescaler, register file, channel counters, interrupt and registered read port
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre <= '0;
      ctrl <= '0;
      status <= '0;
      mask <= '0;
      mode <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= 8'd0;
        count[i] <= 8'd0;
      end
      oe <= 1'b0;
      rdata <= 8'd0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      ctrl <= wr && off == 8'd0 ? wdata : ctrl & ~(expire & mode);
      status <= (status & ~clr) | expire;
      mask <= wr && off == 8'd2 ? wdata : mask;
      mode <= wr && off == 8'd3 ? wdata : mode;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && off == 8'(4 + i)) begin
          period[i] <= BUS_DATA;
          count[i] <= 8'd0;
        end else if (wr && off == 8'd0 && wdata[i] && !ctrl[i])
          count[i] <= 8'd0;
        else if (tick && ctrl[i] && period[i] != 8'd0)
          count[i] <= expire[i] ? 8'd0 : count[i] + 8'd1;
      end
      oe <= rd;
      rdata <= rmux;
      BUS_INTERRUPT_RAISE <= !BUS_INTERRUPT_ACK && (BUS_INTERRUPT_RAISE || |(status & mask));
    end
  end
endmodule
